// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a 64-word data memory: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Define DMEM_ARB_FIXED_PRIORITY_EN to make m0 always win a tie; otherwise ties alternate round-robin.
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wt_data,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_gnt_q, last_gnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pick;
  logic        unused_addr_hi;

  // Winner when at least one request is present in IDLE.
  always_comb begin
    pick = m0_req ? 1'b0 : 1'b1;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    pick = m0_req ? 1'b0 : 1'b1;
`else
    if (m0_req && m1_req) begin
      pick = ~last_gnt_q;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d      = pick;
          last_gnt_d = pick;
          we_d       = pick ? m1_we    : m0_we;
          addr_d     = pick ? m1_addr  : m0_addr;
          wdata_d    = pick ? m1_wdata : m0_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_rd_data;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      last_gnt_q <= 1'b1;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_gnt_q <= last_gnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory is 64 words deep, so only the low address bits reach it.
  assign unused_addr_hi = ^addr_q[31:6];
  assign mem_addr       = {26'd0, addr_q[5:0]};
  assign mem_wt_data    = wdata_q;
  assign mem_MemRead    = (state_q == ACCESS) && !we_q;
  assign mem_MemWrite   = (state_q == ACCESS) && we_q;

  assign m0_gnt  = (state_q == ACCESS) && !win_q;
  assign m1_gnt  = (state_q == ACCESS) &&  win_q;
  assign m0_done = (state_q == RESP)   && !win_q;
  assign m1_done = (state_q == RESP)   &&  win_q;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single accesses, then reset abort, tie arbitration and late-request sequences.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mem_addr, mem_wt_data, mem_rd_data;
  logic        mem_MemRead, mem_MemWrite;

  int total = 0;
  int bad   = 0;

  dmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wt_data(mem_wt_data),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + i * 32'h0000_0101;
  endfunction

  // 64-word memory: combinational read, write on the clock edge.
  logic        init_req;
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_MemWrite) begin
      mem[mem_addr[5:0]] <= mem_wt_data;
    end
  end
  assign mem_rd_data = mem[mem_addr[5:0]];

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [31:0] sh [64];
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("one_hot_gnt_done", 32'($countones({m0_gnt, m1_gnt, m0_done, m1_done}) <= 1), 32'd1);
      chk("rd_wr_excl", 32'(mem_MemRead & mem_MemWrite), 32'd0);
      if (m0_done || m1_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'(m1_done), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_id", 32'(m1_done), 32'(mon_e.id));
          chk("done_rdata", rdata, mon_e.rdata);
        end
      end
    end
  end

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  word;
  } vec_t;
  vec_t vecs[9];

  // Called at a falling edge while the arbiter is IDLE; returns at the next IDLE falling edge.
  task automatic do_access(input vec_t v);
    if (v.m) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    if (v.we) sh[v.word] = v.wdata;
    else      last_rd = sh[v.word];
    exp_q.push_back('{id: v.m, rdata: last_rd});
    @(negedge clk);
    chk("gnt_mine",  32'(v.m ? m1_gnt : m0_gnt), 32'd1);
    chk("gnt_other", 32'(v.m ? m0_gnt : m1_gnt), 32'd0);
    chk("mem_addr",  mem_addr, {26'd0, v.word});
    chk("mem_rd",    32'(mem_MemRead), 32'(!v.we));
    chk("mem_wr",    32'(mem_MemWrite), 32'(v.we));
    chk("wt_data",   mem_wt_data, v.wdata);
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    chk("done_mine", 32'(v.m ? m1_done : m0_done), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int    n_gnt, n_done;
    logic  exp_id [4];

    vecs[0] = '{1'b0, 1'b0, 32'd5,          32'd0,          6'd5};
    vecs[1] = '{1'b1, 1'b1, 32'd3,          32'h12345678,   6'd3};
    vecs[2] = '{1'b0, 1'b0, 32'd3,          32'd0,          6'd3};
    vecs[3] = '{1'b0, 1'b0, 32'd66,         32'd0,          6'd2};
    vecs[4] = '{1'b1, 1'b1, 32'd64,         32'hCAFEF00D,   6'd0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'd0,          6'd63};
    vecs[6] = '{1'b0, 1'b0, 32'd0,          32'd0,          6'd0};
    vecs[7] = '{1'b0, 1'b1, 32'h7F,         32'h55AA55AA,   6'd63};
    vecs[8] = '{1'b1, 1'b0, 32'd63,         32'd0,          6'd63};

    for (int i = 0; i < 64; i++) sh[i] = init_val(i);
    last_rd  = 32'd0;
    reset_n  = 1'b0;
    init_req = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    init_req = 1'b0;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_gnt",   32'({m0_gnt, m1_gnt}), 32'd0);
    chk("rst_done",  32'({m0_done, m1_done}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_memctl", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", mem_wt_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // Reset lands during the ACCESS cycle of an m1 write.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd7; m1_wdata = 32'hA5A5_0007;
    @(negedge clk);
    chk("abort_gnt", 32'(m1_gnt), 32'd1);
    reset_n = 1'b0;
    m1_req  = 1'b0;
    @(negedge clk);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'({m0_done, m1_done}), 32'd0);
    chk("abort_gnt0",  32'({m0_gnt, m1_gnt}), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_wdata", mem_wt_data, 32'd0);
    chk("abort_memctl", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    reset_n = 1'b1;
    last_rd = 32'd0;
    @(negedge clk);
    chk("abort_no_done", 32'({m0_done, m1_done}), 32'd0);

    // Both requesters held: four reads.
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      exp_id[k] = 1'b0;
`else
      exp_id[k] = k[0];
`endif
      exp_q.push_back('{id: exp_id[k], rdata: exp_id[k] ? sh[20] : sh[10]});
    end
    last_rd = exp_id[3] ? sh[20] : sh[10];
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd20;
    n_gnt  = 0;
    n_done = 0;
    for (int c = 0; c < 40 && n_done < 4; c++) begin
      @(negedge clk);
      if ((m0_gnt || m1_gnt) && n_gnt < 4) begin
        chk("tie_order", 32'(m1_gnt), 32'(exp_id[n_gnt]));
        n_gnt++;
      end
      if (m0_done || m1_done) n_done++;
      if (n_done == 4) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("tie_done_count", 32'(n_done), 32'd4);
    @(negedge clk);
    chk("tie_idle", 32'(busy), 32'd0);

    // m1 request raised during the RESP cycle of an m0 read.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd9;
    last_rd = sh[9];
    exp_q.push_back('{id: 1'b0, rdata: last_rd});
    @(negedge clk);
    chk("late_m0_gnt", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    @(negedge clk);
    chk("late_m0_done", 32'(m0_done), 32'd1);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd11;
    last_rd = sh[11];
    exp_q.push_back('{id: 1'b1, rdata: last_rd});
    @(negedge clk);
    chk("late_ignored", 32'(m1_gnt), 32'd0);
    chk("late_idle",    32'(busy), 32'd0);
    @(negedge clk);
    chk("late_m1_gnt", 32'(m1_gnt), 32'd1);
    m1_req = 1'b0;
    @(negedge clk);
    chk("late_m1_done", 32'(m1_done), 32'd1);
    @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
